uart_tx_frame: RTL and testbench

Serial UART transmitter that frames a parallel byte as start bit, DATA_WIDTH data bits LSB first, optional parity bit and one stop bit. It is the transmit-side counterpart of the UART receiver. It runs on the TX baud clock, so each serial bit lasts exactly one clock cycle. The upstream TX FIFO/synchronizer feeds it with a valid/busy handshake.

---
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_tx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART frame transmitter.
// The master is the upstream TX FIFO/synchronizer; the slave is the transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output tx_out,
    output busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: frames a byte as start, DATA_WIDTH data bits LSB first,
// optional parity and one stop bit, one bit per TX baud clock cycle.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [CNT_W-1:0]      bit_cnt_nx_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  tx_out_r;
  logic                  busy_r;
  logic                  tx_out_nx_s;
  logic                  busy_nx_s;
  logic                  accept_s;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    parity_bit = odd ? ~(^d) : (^d);
  endfunction

  assign accept_s = (state_r == IDLE) && bus.data_valid;

  // State and bit counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
    end
  end

  // Frame parameters are captured once, so upstream changes mid-frame are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else if (accept_s) begin
      data_r    <= bus.p_data;
      par_en_r  <= bus.par_en;
      par_typ_r <= bus.par_typ;
    end else begin
      data_r    <= data_r;
      par_en_r  <= par_en_r;
      par_typ_r <= par_typ_r;
    end
  end

  // Next-state and next bit index
  always_comb begin
    state_nx_s   = state_r;
    bit_cnt_nx_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.data_valid) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        state_nx_s   = DATA;
        bit_cnt_nx_s = '0;
      end
      DATA: begin
        if (bit_cnt_r == LAST_IDX) begin
          state_nx_s = par_en_r ? PARITY : STOP;
        end else begin
          state_nx_s   = DATA;
          bit_cnt_nx_s = bit_cnt_r + CNT_W'(1);
        end
      end
      PARITY:  state_nx_s = STOP;
      STOP:    state_nx_s = IDLE;
      default: begin
        state_nx_s   = IDLE;
        bit_cnt_nx_s = '0;
      end
    endcase
  end

  // Line level for the upcoming state; registered below so outputs are glitch-free
  always_comb begin
    tx_out_nx_s = 1'b1;
    busy_nx_s   = 1'b0;
    case (state_nx_s)
      IDLE: begin
        tx_out_nx_s = 1'b1;
        busy_nx_s   = 1'b0;
      end
      START: begin
        tx_out_nx_s = 1'b0;
        busy_nx_s   = 1'b1;
      end
      DATA: begin
        tx_out_nx_s = data_r[bit_cnt_nx_s];
        busy_nx_s   = 1'b1;
      end
      PARITY: begin
        tx_out_nx_s = parity_bit(data_r, par_typ_r);
        busy_nx_s   = 1'b1;
      end
      STOP: begin
        tx_out_nx_s = 1'b1;
        busy_nx_s   = 1'b1;
      end
      default: begin
        tx_out_nx_s = 1'b1;
        busy_nx_s   = 1'b0;
      end
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_out_r <= tx_out_nx_s;
      busy_r   <= busy_nx_s;
    end
  end

  assign bus.tx_out = tx_out_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a frame-level model predicts which requests
// are accepted and what each frame looks like; a line monitor compares bursts.
module tb_uart_tx_frame;
  localparam int W = 8;

  typedef struct {
    int          start;
    int          len;
    logic [31:0] bits;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   next_free = 1;
  frame_t exp_q[$];

  uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Expected line contents of a whole frame, built from the framing rules
  function automatic frame_t make_frame(int s, logic [W-1:0] d, logic pen, logic ptyp);
    frame_t f;
    int ones;
    f.start = s;
    f.bits  = '0;
    ones    = $countones(d);
    f.bits[0] = 1'b0;
    for (int i = 0; i < W; i++) f.bits[1+i] = d[i];
    f.len = 1 + W;
    if (pen) begin
      f.bits[f.len] = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
      f.len++;
    end
    f.bits[f.len] = 1'b1;
    f.len++;
    return f;
  endfunction

  // Drive inputs for the next rising edge and update the model of that edge
  task automatic apply(logic r, logic v, logic [W-1:0] d, logic pen, logic ptyp);
    int e;
    frame_t f;
    int last;
    rst            = r;
    bus.data_valid = v;
    bus.p_data     = d;
    bus.par_en     = pen;
    bus.par_typ    = ptyp;
    e = edge_cnt + 1;
    if (r) begin
      if (exp_q.size() > 0) begin
        last = exp_q.size() - 1;
        if (exp_q[last].start < e && e < exp_q[last].start + exp_q[last].len)
          exp_q[last].len = e - exp_q[last].start;
      end
      next_free = e + 1;
    end else if (v && e >= next_free) begin
      f = make_frame(e, d, pen, ptyp);
      exp_q.push_back(f);
      next_free = e + f.len + 1;
    end
  endtask

  task automatic drive(logic r, logic v, logic [W-1:0] d, logic pen, logic ptyp);
    @(negedge clk);
    apply(r, v, d, pen, ptyp);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Line monitor: collects each busy burst and checks it against the scoreboard
  initial begin : monitor
    bit          in_f;
    int          s;
    int          n;
    logic [31:0] got;
    logic [31:0] mask;
    frame_t      f;
    in_f = 1'b0;
    s    = 0;
    n    = 0;
    got  = '0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        if (!in_f) begin
          in_f = 1'b1;
          s    = edge_cnt;
          n    = 0;
          got  = '0;
        end
        if (n < 32) got[n] = bus.tx_out;
        n++;
      end else begin
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_line: tx_out=%b busy=%b, want tx_out=1 busy=0 (edge %0d)",
                   bus.tx_out, bus.busy, edge_cnt);
        end
        if (in_f) begin
          in_f = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: frame at edge %0d len %0d, want none", s, n);
          end else begin
            f = exp_q.pop_front();
            checks++;
            if (s != f.start) begin
              errors++;
              $display("FAIL frame_start: started after edge %0d, want %0d", s, f.start);
            end
            checks++;
            if (n != f.len) begin
              errors++;
              $display("FAIL frame_len: busy for %0d cycles, want %0d (start %0d)", n, f.len, f.start);
            end
            mask = '0;
            for (int i = 0; i < f.len && i < 32; i++) mask[i] = 1'b1;
            checks++;
            if (((got ^ f.bits) & mask) != 32'h0) begin
              errors++;
              $display("FAIL frame_bits: line %b, want %b (LSB first, start %0d)",
                       got & mask, f.bits & mask, f.start);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held 3 cycles with data_valid high: no frame may start
    apply(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle(4);

    // 0xA5 without parity, with even parity, with odd parity
    drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle(12);
    drive(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle(13);
    drive(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    idle(13);

    // data_valid held high, payload changed to 0x3C mid-frame
    for (int i = 0; i < 12; i++)
      drive(1'b0, 1'b1, (i < 3) ? 8'hA5 : 8'h3C, 1'b0, 1'b0);
    idle(14);

    // Reset during data bit 4 of 0xFF, then a clean 0x00 frame
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle(5);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(13);

    // Parity corner cases
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    idle(13);
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    idle(13);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));

    // Drain with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames still expected, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
